// File: rtl/pe_ctrl_pkg.sv
// Shared types and bound helpers for the PE array sequencing controller.
// Imported by pe_array_ctrl and pe_skew_gen.
package pe_ctrl_pkg;

    localparam int PE_CTRL_GW = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        RUN,
        DONE
    } pe_ctrl_state_t;

    // Last value of the LOAD_W counter: one extra cycle lets b_en trail the final read.
    function automatic logic [PE_CTRL_GW-1:0] load_last(input int rows);
        return PE_CTRL_GW'(rows);
    endfunction

    // Last value of the RUN counter: final column drains its last vector at this g.
    function automatic logic [PE_CTRL_GW-1:0] run_last(input logic [7:0] n, input int rows,
                                                       input int cols, input int pipe_lat);
        return PE_CTRL_GW'(int'(n) + rows + cols + pipe_lat - 1);
    endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Buffer/array/scheduler signal bundle for pe_array_ctrl.
// Carries reuse_w only when PE_CTRL_WEIGHT_REUSE_EN is defined.
interface pe_array_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    logic                      start;
    logic [7:0]                num_vec;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    logic                      reuse_w;
`endif
    logic                      busy;
    logic                      done;
    logic                      w_rd_en;
    logic [$clog2(ROWS)-1:0]   w_rd_addr;
    logic                      b_en;
    logic                      a_rd_en;
    logic [7:0]                a_rd_addr;
    logic [ROWS-1:0]           a_row_en;
    logic [COLS-1:0]           out_valid;

    modport master (
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        input  reuse_w,
`endif
        input  start, num_vec,
        output busy, done, w_rd_en, w_rd_addr, b_en,
        output a_rd_en, a_rd_addr, a_row_en, out_valid
    );

    modport slave (
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        output reuse_w,
`endif
        output start, num_vec,
        input  busy, done, w_rd_en, w_rd_addr, b_en,
        input  a_rd_en, a_rd_addr, a_row_en, out_valid
    );
endinterface

// File: rtl/pe_skew_gen.sv
// Per-row input enables and per-column capture strobes derived from the RUN counter.
// Pure compare logic; everything is gated low outside RUN.
module pe_skew_gen
    import pe_ctrl_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int PIPE_LAT = 1
) (
    input  logic                  run,
    input  logic [PE_CTRL_GW-1:0] g,
    input  logic [7:0]            n,
    output logic [ROWS-1:0]       a_row_en,
    output logic [COLS-1:0]       out_valid
);
    logic [PE_CTRL_GW-1:0] n_w;
    assign n_w = PE_CTRL_GW'(n);

    // Row r sees vector v at g = r+1+v; the skew staggers rows by one cycle each.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        localparam logic [PE_CTRL_GW-1:0] ROW_LO = PE_CTRL_GW'(gi + 1);
        localparam logic [PE_CTRL_GW-1:0] ROW_OFS = PE_CTRL_GW'(gi);
        assign a_row_en[gi] = run && (g >= ROW_LO) && (g <= ROW_OFS + n_w);
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        localparam logic [PE_CTRL_GW-1:0] COL_LO = PE_CTRL_GW'(ROWS + PIPE_LAT + gi + 1);
        localparam logic [PE_CTRL_GW-1:0] COL_OFS = PE_CTRL_GW'(ROWS + PIPE_LAT + gi);
        assign out_valid[gi] = run && (g >= COL_LO) && (g <= COL_OFS + n_w);
    end

endmodule

// File: rtl/pe_array_ctrl.sv
// Weight-stationary PE array sequencer: LOAD_W weight rows, then RUN skewed activations.
// Optional PE_CTRL_WEIGHT_REUSE_EN adds reuse_w to skip LOAD_W and keep current weights.
module pe_array_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    pe_array_ctrl_if.master   bus
);
    localparam int AW = $clog2(ROWS);

    pe_ctrl_state_t        state_reg, state_next;
    logic [PE_CTRL_GW-1:0] cnt_reg, cnt_next;
    logic [7:0]            n_reg, n_next;

    logic          busy, done, w_rd_en, b_en, a_rd_en, run;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    a_rd_addr;
    logic          reuse;

`ifdef PE_CTRL_WEIGHT_REUSE_EN
    assign reuse = bus.reuse_w;
`else
    assign reuse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            n_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            n_reg     <= n_next;
        end
    end

    // One counter serves as k in LOAD_W and g in RUN; it is cleared on every state change.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        n_next     = n_reg;
        busy       = 1'b1;
        done       = 1'b0;
        w_rd_en    = 1'b0;
        w_rd_addr  = '0;
        b_en       = 1'b0;
        a_rd_en    = 1'b0;
        a_rd_addr  = '0;
        run        = 1'b0;
        case (state_reg)
            IDLE: begin
                busy     = 1'b0;
                cnt_next = '0;
                if (bus.start) begin
                    if (bus.num_vec == 8'd0) begin
                        state_next = DONE;
                    end else begin
                        n_next     = bus.num_vec;
                        state_next = reuse ? RUN : LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (cnt_reg < load_last(ROWS)) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = AW'(ROWS - 1 - int'(cnt_reg));
                end
                // Read data lands one cycle later, so the shift enable trails the read by one.
                b_en = (cnt_reg != '0);
                if (cnt_reg == load_last(ROWS)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                run = 1'b1;
                if (cnt_reg < PE_CTRL_GW'(n_reg)) begin
                    a_rd_en   = 1'b1;
                    a_rd_addr = cnt_reg[7:0];
                end
                if (cnt_reg == run_last(n_reg, ROWS, COLS, PIPE_LAT)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    pe_skew_gen #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .PIPE_LAT (PIPE_LAT)
    ) u_skew (
        .run       (run),
        .g         (cnt_reg),
        .n         (n_reg),
        .a_row_en  (bus.a_row_en),
        .out_valid (bus.out_valid)
    );

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.w_rd_en   = w_rd_en;
    assign bus.w_rd_addr = w_rd_addr;
    assign bus.b_en      = b_en;
    assign bus.a_rd_en   = a_rd_en;
    assign bus.a_rd_addr = a_rd_addr;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: a pass-level model queues per-cycle expected outputs,
// a negedge monitor compares every cycle (idle expected when nothing is queued).
module tb_pe_array_ctrl;
    localparam int R = 4;
    localparam int C = 4;
    localparam int P = 1;

    typedef struct {
        int         cyc;
        logic       busy;
        logic       done;
        logic       w_rd_en;
        logic [1:0] w_rd_addr;
        logic       b_en;
        logic       a_rd_en;
        logic [7:0] a_rd_addr;
        logic [3:0] a_row_en;
        logic [3:0] out_valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   busy_end = -1;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    pe_array_ctrl_if #(.ROWS(R), .COLS(C)) bus();

    pe_array_ctrl #(.ROWS(R), .COLS(C), .PIPE_LAT(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic exp_t idle_exp(int c);
        exp_t e;
        e.cyc = c; e.busy = 0; e.done = 0; e.w_rd_en = 0; e.w_rd_addr = 0; e.b_en = 0;
        e.a_rd_en = 0; e.a_rd_addr = 0; e.a_row_en = 0; e.out_valid = 0;
        return e;
    endfunction

    // Expected behaviour of one accepted pass, from the cycle timeline of the controller.
    task automatic model_pass(int s, int n, bit reuse);
        exp_t e;
        int rs, last;
        if (n == 0) begin
            e = idle_exp(s + 1); e.busy = 1; e.done = 1; q.push_back(e);
            busy_end = s + 1;
            return;
        end
        if (reuse) begin
            rs = s + 1;
        end else begin
            for (int k = 0; k <= R; k++) begin
                e = idle_exp(s + 1 + k);
                e.busy = 1;
                e.w_rd_en = (k < R);
                if (k < R) e.w_rd_addr = 2'(R - 1 - k);
                e.b_en = (k >= 1);
                q.push_back(e);
            end
            rs = s + R + 2;
        end
        last = n + R + C + P - 1;
        for (int g = 0; g <= last; g++) begin
            e = idle_exp(rs + g);
            e.busy = 1;
            if (g < n) begin
                e.a_rd_en = 1;
                e.a_rd_addr = 8'(g);
            end
            for (int r = 0; r < R; r++) e.a_row_en[r] = (g >= r + 1) && (g <= r + n);
            for (int c = 0; c < C; c++) e.out_valid[c] = (g >= R + P + c + 1) && (g <= R + P + c + n);
            q.push_back(e);
        end
        e = idle_exp(rs + last + 1); e.busy = 1; e.done = 1; q.push_back(e);
        busy_end = rs + last + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_idle();
        while (cyc <= busy_end) tick();
    endtask

    // Pulse start for one cycle; the model decides whether the controller accepts it.
    task automatic do_start(int n, bit reuse);
        int  s;
        bit  reuse_eff;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        reuse_eff = reuse;
`else
        reuse_eff = 1'b0;
`endif
        s = cyc;
        if (s > busy_end) begin
            model_pass(s, n, reuse_eff);
            $display("pass start cycle=%0d num_vec=%0d reuse=%0d expect_done=%0d", s, n, reuse_eff, busy_end);
        end else begin
            $display("start ignored cycle=%0d num_vec=%0d (busy until %0d)", s, n, busy_end);
        end
        bus.start = 1'b1;
        bus.num_vec = 8'(n);
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        bus.reuse_w = reuse;
`endif
        tick();
        bus.start = 1'b0;
        bus.num_vec = 8'($urandom);
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        bus.reuse_w = 1'($urandom);
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                errors++;
                $display("FAIL stale_expect: entry for cycle %0d not consumed, now cycle %0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
            else e = idle_exp(cyc);
            checks++;
            if ({bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr, bus.b_en, bus.a_rd_en,
                 bus.a_rd_addr, bus.a_row_en, bus.out_valid} !==
                {e.busy, e.done, e.w_rd_en, e.w_rd_addr, e.b_en, e.a_rd_en,
                 e.a_rd_addr, e.a_row_en, e.out_valid}) begin
                errors++;
                $display("FAIL cycle_outputs @%0d: got busy=%b done=%b wen=%b waddr=%0d b_en=%b aen=%b aaddr=%0d row=%b ov=%b, want busy=%b done=%b wen=%b waddr=%0d b_en=%b aen=%b aaddr=%0d row=%b ov=%b",
                         cyc, bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr, bus.b_en, bus.a_rd_en,
                         bus.a_rd_addr, bus.a_row_en, bus.out_valid,
                         e.busy, e.done, e.w_rd_en, e.w_rd_addr, e.b_en, e.a_rd_en,
                         e.a_rd_addr, e.a_row_en, e.out_valid);
            end
        end
    end

    initial begin
        int s, n;
        bus.start = 1'b0;
        bus.num_vec = 8'd0;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        bus.reuse_w = 1'b0;
`endif
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        busy_end = cyc;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Nominal pass, an ignored start mid-pass, then a back-to-back start.
        s = cyc;
        do_start(3, 0);
        wait_until(s + 10);
        do_start(7, 0);
        wait_until(s + 19);
        do_start(5, 0);
        wait_idle();
        tick();

        // Zero-length pass.
        do_start(0, 0);
        wait_idle();
        tick();

        // Reset mid-pass: outputs drop to zero the cycle after, and no done follows.
        s = cyc;
        do_start(3, 0);
        wait_until(s + 8);
        rst = 1'b1;
        while (q.size() > 0 && q[q.size()-1].cyc > s + 8) q.delete(q.size() - 1);
        busy_end = s + 8;
        $display("reset asserted cycle=%0d", cyc);
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Longest pass.
        do_start(255, 0);
        wait_idle();
        tick();

`ifdef PE_CTRL_WEIGHT_REUSE_EN
        do_start(2, 1);
        wait_idle();
        tick();
`endif

        // Randomised passes with stray starts and input churn while busy.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            do_start(n, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 12)) tick();
                do_start(int'($urandom_range(0, 255)), 1'($urandom));
            end
            wait_idle();
        end

        repeat (3) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending entries, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
